serial_alu_ctrl: RTL and testbench
==================================

# serial_alu_ctrl

Bit-serial add/subtract engine built around a single 1-bit full adder (`FA`: inputs `a`, `b`, `c0`; outputs `s`, `Ca`). The block sequences that full adder over `WIDTH` cycles, LSB first, to produce a `WIDTH`-bit sum or difference with carry, overflow and zero flags. It sits between the ALU operand registers and the result bus. It is the low-area alternative to the parallel ripple adder.

## Interface
- `WIDTH`, default 8, operand and result width in bits (legal range ≥ 2).
- `clk`  in  1  single clock; everything is updated on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = add (a+b), 1 = subtract (a−b); latched with `start`.
- `a`  in  WIDTH  operand A; latched with `start`.
- `b`  in  WIDTH  operand B; latched with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result and flags are valid from this cycle onward.
- `result`  out  WIDTH  sum or difference; held until the next accepted `start` or reset.
- `cout`  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- `zero`  out  1  `result == 0`.

## Operation
- **Exactly one `FA` instance.** It is driven each RUN cycle as follows:
  - `a` = A shift register bit 0.
  - `b` = B shift register bit 0, XORed with the latched `op`.
  - `c0` = carry register.
- **States:** IDLE, RUN, DONE. Transitions:
  - IDLE → RUN when `start` = 1.
  - RUN → DONE when bit counter = `WIDTH`−1.
  - DONE → IDLE unconditionally.
- **On an accepted start:**
  - Latch `a` and `b` into shift registers and latch `op`.
  - Carry register ← `op` (two's-complement +1 for subtract).
  - Clear the bit counter and the result shift register.
- **Each RUN cycle:**
  - The `FA` sum bit shifts into the result register at the MSB, and the register shifts right.
  - The A and B registers shift right.
  - Carry register ← `Ca`.
  - Counter increments. It is `$clog2(WIDTH)` bits wide and does not wrap past `WIDTH`−1.
- **Last RUN cycle (counter = `WIDTH`−1):**
  - Capture the `FA` carry-in (the carry register value) as `cin_msb`.
  - `cout` ← `Ca`.
  - `ovf` ← `cin_msb` XOR `Ca`.
  - `zero` ← (final result value == 0), computed including the incoming sum bit.
- **`start` in RUN or DONE:** ignored; not queued.
- **Reset:** `rst` in any state, including mid-RUN, forces IDLE on that edge and abandons the operation.
  - `result`, `cout`, `ovf`, `zero`, `busy`, `done`, counter, carry and shift registers all become 0.
  - No `done` is produced for the abandoned operation.
- **`rst` and `start` in the same cycle:** reset wins; `start` is not accepted.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `result` = 0, `cout` = 0, `ovf` = 0, `zero` = 0.
- **Start accepted:** `start` is sampled high in IDLE at edge T.
  - `busy` = 1 during cycles T+1 … T+`WIDTH`.
  - Bit i is processed in cycle T+1+i.
- **Completion:**
  - `done` = 1 and `busy` = 0 in cycle T+`WIDTH`+1.
  - `result` and flags are stable from that cycle.
  - Latency from start to done is `WIDTH`+1 cycles.
- **Next operation:** earliest next accepted `start` is sampled at edge T+`WIDTH`+2 (back in IDLE). Throughput is one operation per `WIDTH`+2 cycles.
- **Held values:** `result`/flags do not change during a RUN; outputs update only at the DONE transition. The internal shift register is separate from the `result` output register.
- **Input changes:** `a`, `b` and `op` may change freely after the accepting edge without effect.

## Test plan
All scenarios use `WIDTH` = 8.
1. Add, 8'h0F + 8'h01 → `result` = 8'h10, `cout` = 0, `ovf` = 0, `zero` = 0. `done` is exactly 9 cycles after the `start` edge; `busy` is high for exactly 8 cycles.
2. Add with overflow and carry:
   - 8'h7F + 8'h01 → 8'h80, `ovf` = 1, `cout` = 0.
   - 8'hFF + 8'h01 → 8'h00, `cout` = 1, `ovf` = 0, `zero` = 1.
3. Subtract:
   - 8'h05 − 8'h05 → 8'h00, `cout` = 1, `zero` = 1.
   - 8'h03 − 8'h05 → 8'hFE, `cout` = 0, `ovf` = 0.
   - 8'h80 − 8'h01 → 8'h7F, `ovf` = 1.
4. Ignored start: pulse `start` with new operands during RUN and during DONE → the first result is unaffected, there is no extra `done`, and the block is in IDLE afterwards.
5. Reset mid-RUN: assert `rst` at the 4th RUN cycle → next cycle has `busy` = 0, all outputs 0, and no `done`. A following start with 8'h22 + 8'h11 → 8'h33 with normal latency.
6. Back-to-back: assert `start` at the first IDLE cycle after `done` → accepted. The previous `result` is held until the new `done`, and the new `done` comes `WIDTH`+1 cycles later.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// ============================================================================
// Module      : serial_alu_ctrl (with helper serial_alu_fa)
// Description : Bit-serial add/subtract engine. One 1-bit full adder is
//               stepped over WIDTH cycles, LSB first, to form a WIDTH-bit
//               sum or difference plus carry, signed overflow and zero flags.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start, op, a, b   - request, 0=add 1=sub, operands
//                                   (all sampled only while idle)
//               busy              - high while bits are being processed
//               done              - one-cycle pulse when results are valid
//               result, cout,
//               ovf, zero         - held until the next accepted start/reset
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_fa (
  input  logic a,
  input  logic b,
  input  logic c0,
  output logic s,
  output logic Ca
);
  assign s  = a ^ b ^ c0;
  assign Ca = (a & b) | (a & c0) | (b & c0);
endmodule

module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  // Only WIDTH-1 bits are stored: the final sum bit is merged in directly
  // when the output register is loaded on the last RUN cycle.
  logic [WIDTH-2:0] r_sh_res;
  logic             r_op;
  logic             r_carry;
  logic [C_CW-1:0]  r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_sum;
  logic             w_ca;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_res_full;

  serial_alu_fa u_fa (
    .a  (r_sh_a[0]),
    .b  (r_sh_b[0] ^ r_op),
    .c0 (r_carry),
    .s  (w_sum),
    .Ca (w_ca)
  );

  assign w_accept   = (r_state == IDLE) && start;
  assign w_last     = (r_state == RUN) && (r_cnt == C_LAST);
  // On the last bit the carry register holds the carry into the MSB.
  assign w_cin_msb  = r_carry;
  assign w_res_full = {w_sum, r_sh_res};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == C_LAST) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand/result shifting and output capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_sh_res <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (w_accept) begin
      r_sh_a   <= a;
      r_sh_b   <= b;
      r_op     <= op;
      r_carry  <= op;  // +1 of the two's complement for subtract
      r_cnt    <= '0;
      r_sh_res <= '0;
    end else if (r_state == RUN) begin
      r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
      r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
      r_sh_res <= w_res_full[WIDTH-1:1];
      r_carry  <= w_ca;
      if (w_last) begin
        result <= w_res_full;
        cout   <= w_ca;
        ovf    <= w_cin_msb ^ w_ca;
        zero   <= (w_res_full == '0);
      end else begin
        r_cnt  <= r_cnt + C_CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
// ============================================================================
// Module      : tb_serial_alu_ctrl
// Description : Directed self-checking bench for serial_alu_ctrl, WIDTH = 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  int passed;
  int total;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic launch(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles (sampled at negedge) until done; lat = 0 means no done seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (result !== 8'h00) $display("FAIL reset_result: got %h want 00", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b000)
      $display("FAIL reset_flags: got cout/ovf/zero=%b want 000", {cout, ovf, zero}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat, bc;
    launch(1'b0, 8'h0F, 8'h01);
    wait_done(lat, bc);
    total++; if (lat !== 9) $display("FAIL add_latency: got %0d want 9", lat); else passed++;
    total++; if (bc !== 8) $display("FAIL add_busy_cycles: got %0d want 8", bc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL add_busy_at_done: got %b want 0", busy); else passed++;
    total++; if (result !== 8'h10) $display("FAIL add_result: got %h want 10", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b000)
      $display("FAIL add_flags: got cout/ovf/zero=%b want 000", {cout, ovf, zero}); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", done); else passed++;
    total++; if (result !== 8'h10) $display("FAIL add_result_held: got %h want 10", result); else passed++;
  endtask

  task automatic test_add_ovf;
    int lat, bc;
    launch(1'b0, 8'h7F, 8'h01);
    wait_done(lat, bc);
    total++; if (lat !== 9) $display("FAIL ovf_latency: got %0d want 9", lat); else passed++;
    total++; if (result !== 8'h80) $display("FAIL ovf_result: got %h want 80", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b010)
      $display("FAIL ovf_flags: got cout/ovf/zero=%b want 010", {cout, ovf, zero}); else passed++;
    launch(1'b0, 8'hFF, 8'h01);
    wait_done(lat, bc);
    total++; if (result !== 8'h00) $display("FAIL carry_result: got %h want 00", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b101)
      $display("FAIL carry_flags: got cout/ovf/zero=%b want 101", {cout, ovf, zero}); else passed++;
  endtask

  task automatic test_sub;
    int lat, bc;
    launch(1'b1, 8'h05, 8'h05);
    wait_done(lat, bc);
    total++; if (result !== 8'h00) $display("FAIL sub_eq_result: got %h want 00", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b101)
      $display("FAIL sub_eq_flags: got cout/ovf/zero=%b want 101", {cout, ovf, zero}); else passed++;
    launch(1'b1, 8'h03, 8'h05);
    wait_done(lat, bc);
    total++; if (result !== 8'hFE) $display("FAIL sub_borrow_result: got %h want fe", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b000)
      $display("FAIL sub_borrow_flags: got cout/ovf/zero=%b want 000", {cout, ovf, zero}); else passed++;
    launch(1'b1, 8'h80, 8'h01);
    wait_done(lat, bc);
    total++; if (result !== 8'h7F) $display("FAIL sub_ovf_result: got %h want 7f", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b110)
      $display("FAIL sub_ovf_flags: got cout/ovf/zero=%b want 110", {cout, ovf, zero}); else passed++;
  endtask

  task automatic test_ignored_start;
    int lat, bc, extra;
    launch(1'b0, 8'h11, 8'h22);
    repeat (3) @(negedge clk);
    op = 1'b1; a = 8'hFF; b = 8'hFF; start = 1'b1;   // during RUN
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    total++; if (lat !== 5) $display("FAIL ign_latency: got %0d want 5", lat); else passed++;
    total++; if (result !== 8'h33) $display("FAIL ign_result: got %h want 33", result); else passed++;
    op = 1'b0; a = 8'h01; b = 8'h01; start = 1'b1;   // during DONE
    @(negedge clk);
    start = 1'b0;
    total++; if ({busy, done} !== 2'b00)
      $display("FAIL ign_idle: got busy/done=%b want 00", {busy, done}); else passed++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    total++; if (extra !== 0) $display("FAIL ign_no_extra: got %0d active cycles want 0", extra); else passed++;
    total++; if (result !== 8'h33) $display("FAIL ign_result_held: got %h want 33", result); else passed++;
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, extra;
    launch(1'b0, 8'h55, 8'h0F);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({busy, done} !== 2'b00)
      $display("FAIL rst_run_status: got busy/done=%b want 00", {busy, done}); else passed++;
    total++; if ({result, cout, ovf, zero} !== 11'h000)
      $display("FAIL rst_run_outputs: got result=%h flags=%b want 00 000", result, {cout, ovf, zero}); else passed++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    total++; if (extra !== 0) $display("FAIL rst_run_no_done: got %0d active cycles want 0", extra); else passed++;
    // reset and start together: start must not be accepted
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 1'b0; a = 8'h01; b = 8'h02;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_start_same: got busy %b want 0", busy); else passed++;
    launch(1'b0, 8'h22, 8'h11);
    wait_done(lat, bc);
    total++; if (lat !== 9) $display("FAIL rst_after_latency: got %0d want 9", lat); else passed++;
    total++; if (result !== 8'h33) $display("FAIL rst_after_result: got %h want 33", result); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc, bad;
    launch(1'b0, 8'h10, 8'h20);
    wait_done(lat, bc);
    total++; if (result !== 8'h30) $display("FAIL b2b_first: got %h want 30", result); else passed++;
    launch(1'b1, 8'h40, 8'h01);   // presented in the first IDLE cycle
    lat = 0;
    bad = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (result !== 8'h30) bad++;
    end
    total++; if (lat !== 9) $display("FAIL b2b_latency: got %0d want 9", lat); else passed++;
    total++; if (bad !== 0) $display("FAIL b2b_held: got %0d changed cycles want 0", bad); else passed++;
    total++; if (result !== 8'h3F) $display("FAIL b2b_result: got %h want 3f", result); else passed++;
    total++; if ({cout, ovf, zero} !== 3'b100)
      $display("FAIL b2b_flags: got cout/ovf/zero=%b want 100", {cout, ovf, zero}); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    a      = '0;
    b      = '0;
    test_reset();
    test_add();
    test_add_ovf();
    test_sub();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
